// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int          XLEN       = 32;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam int          INST_ALIGN = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        OUT
    } state_e;

    typedef enum logic [1:0] {
        NPC_HOLD,
        NPC_INC,
        NPC_REDIRECT
    } npc_sel_e;

endpackage

// File: rtl/fetch_unit_npc_mux.sv
// Next-PC select: hold, sequential increment, or aligned redirect target.
module fetch_unit_npc_mux
    import fetch_unit_pkg::*;
(
    input  npc_sel_e         sel,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  target,
    output logic [XLEN-1:0]  npc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_ALIGN - 1));

    always_comb begin
        npc = pc;
        unique case (sel)
            NPC_INC:      npc = pc + XLEN'(INST_ALIGN);
            NPC_REDIRECT: npc = target & ALIGN_MASK;
            default:      npc = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, valid/ready delivery to decode,
// and the next-PC fed back to a PC register that has no enable.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_in,
    output logic [XLEN-1:0]  npc_out,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             inst_valid,
    output logic [XLEN-1:0]  inst,
    output logic [XLEN-1:0]  inst_pc,
    input  logic             inst_ready,
    output logic [31:0]      fetch_count
);

    state_e          state_q, state_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]     fetch_count_q, fetch_count_d;
    npc_sel_e        npc_sel;

    assign inst_valid  = (state_q == OUT);
    assign inst        = inst_valid ? inst_q : NOP_INST;
    assign inst_pc     = inst_pc_q;
    assign imem_addr   = pc_in;
    assign fetch_count = fetch_count_q;

    // Redirect wins over everything; a redirect while a response is still in
    // flight arms drop so that stale response is swallowed on arrival.
    always_comb begin
        state_d       = state_q;
        drop_d        = drop_q;
        req_pc_d      = req_pc_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        fetch_count_d = fetch_count_q + {31'd0, inst_valid & inst_ready};
        imem_req      = 1'b0;
        npc_sel       = NPC_HOLD;

        if (redirect_valid) begin
            npc_sel = NPC_REDIRECT;
            unique case (state_q)
                WAIT: begin
                    if (imem_rvalid) begin
                        state_d = IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    imem_req = 1'b1;
                    if (imem_gnt) begin
                        req_pc_d = pc_in;
                        npc_sel  = NPC_INC;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            inst_d    = imem_rdata;
                            inst_pc_d = req_pc_q;
                            state_d   = OUT;
                        end
                    end
                end
                OUT: begin
                    imem_req = inst_ready;
                    if (inst_ready) begin
                        if (imem_gnt) begin
                            req_pc_d = pc_in;
                            npc_sel  = NPC_INC;
                            state_d  = WAIT;
                        end else begin
                            state_d  = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (rst) begin
            imem_req = 1'b0;
            npc_sel  = NPC_HOLD;
        end
    end

    fetch_unit_npc_mux u_npc_mux (
        .sel    (npc_sel),
        .pc     (pc_in),
        .target (redirect_target),
        .npc    (npc_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            drop_q        <= 1'b0;
            req_pc_q      <= '0;
            inst_q        <= NOP_INST;
            inst_pc_q     <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            drop_q        <= drop_d;
            req_pc_q      <= req_pc_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays the PC register and imem,
// and a scoreboard matches every delivered instruction against what memory returned.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] npc_out;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] fetch_count;

    // Each entry is {expected inst_pc, expected inst}.
    logic [63:0] exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .pc_in           (pc_in),
        .npc_out         (npc_out),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready),
        .fetch_count     (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Scoreboard pop on a decode handshake, then clock the PC register model.
    task automatic advance();
        logic [31:0] npc_seen;
        logic [63:0] e;
        if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_inst", inst, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                chk("sb_inst", inst, e[31:0]);
                chk("sb_inst_pc", inst_pc, e[63:32]);
            end
        end
        npc_seen = npc_out;
        @(posedge clk);
        #1;
        pc_in = npc_seen;
    endtask

    task automatic drive(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                         input logic ready, input logic redir, input logic [31:0] tgt);
        imem_gnt        = gnt;
        imem_rvalid     = rvalid;
        imem_rdata      = rdata;
        inst_ready      = ready;
        redirect_valid  = redir;
        redirect_target = tgt;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] req_pc;

        rst = 1'b1;
        pc_in = 32'h0;
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // Reset
        repeat (2) begin
            sample();
            chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
            chk("rst_npc", npc_out, pc_in);
            advance();
        end
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fetch_count", fetch_count, 32'd0);
        rst = 1'b0;

        // First fetch at 0x0
        sample();
        chk("c1_req", {31'd0, imem_req}, 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        chk("c1_npc", npc_out, 32'h4);
        advance();

        drive(1'b1, 1'b1, 32'h0050_0093, 1'b1, 1'b0, 32'h0);
        exp_q.push_back({32'h0, 32'h0050_0093});
        sample();
        chk("c2_req", {31'd0, imem_req}, 32'd0);
        chk("c2_npc_hold", npc_out, 32'h4);
        chk("c2_inst_valid", {31'd0, inst_valid}, 32'd0);
        advance();

        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        sample();
        chk("c3_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("c3_inst", inst, 32'h0050_0093);
        chk("c3_inst_pc", inst_pc, 32'h0);
        chk("c3_addr", imem_addr, 32'h4);
        chk("c3_npc", npc_out, 32'h8);
        advance();

        drive(1'b1, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0);
        exp_q.push_back({32'h4, 32'h1111_1111});
        sample();
        chk("c4_fetch_count", fetch_count, 32'd1);
        advance();

        // Backpressure: three cycles without inst_ready
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("bp_inst_valid", {31'd0, inst_valid}, 32'd1);
            chk("bp_inst", inst, 32'h1111_1111);
            chk("bp_inst_pc", inst_pc, 32'h4);
            chk("bp_req", {31'd0, imem_req}, 32'd0);
            chk("bp_npc", npc_out, pc_in);
            chk("bp_fetch_count", fetch_count, 32'd1);
            advance();
        end

        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        sample();
        chk("bp_rel_req", {31'd0, imem_req}, 32'd1);
        chk("bp_rel_addr", imem_addr, 32'h8);
        chk("bp_rel_npc", npc_out, 32'hC);
        advance();

        drive(1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h0);
        exp_q.push_back({32'h8, 32'h2222_2222});
        sample();
        chk("c9_fetch_count", fetch_count, 32'd2);
        advance();

        // Accept without grant: falls back to IDLE
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        sample();
        chk("nogrant_req", {31'd0, imem_req}, 32'd1);
        chk("nogrant_npc", npc_out, 32'hC);
        advance();

        // Grant delayed four cycles in IDLE
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("gd_req", {31'd0, imem_req}, 32'd1);
            chk("gd_addr", imem_addr, 32'hC);
            chk("gd_npc", npc_out, 32'hC);
            advance();
        end

        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        sample();
        chk("gd_grant_npc", npc_out, 32'h10);
        advance();

        // Redirect in WAIT; pending response must be dropped
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0102);
        sample();
        chk("rw_npc", npc_out, 32'h0000_0100);
        chk("rw_req", {31'd0, imem_req}, 32'd0);
        advance();

        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        sample();
        chk("rw_drop_valid", {31'd0, inst_valid}, 32'd0);
        chk("rw_drop_req", {31'd0, imem_req}, 32'd0);
        chk("rw_drop_npc", npc_out, 32'h100);
        advance();

        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        sample();
        chk("rw_after_valid", {31'd0, inst_valid}, 32'd0);
        chk("rw_after_req", {31'd0, imem_req}, 32'd1);
        chk("rw_after_addr", imem_addr, 32'h100);
        chk("rw_after_npc", npc_out, 32'h104);
        advance();

        drive(1'b1, 1'b1, 32'h3333_3333, 1'b1, 1'b0, 32'h0);
        exp_q.push_back({32'h100, 32'h3333_3333});
        sample();
        advance();

        // Redirect in OUT together with an accept
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        sample();
        chk("ro_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("ro_req", {31'd0, imem_req}, 32'd0);
        chk("ro_npc", npc_out, 32'hFFFF_FFFC);
        advance();

        // Wrap of pc+4
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        sample();
        chk("ro_next_valid", {31'd0, inst_valid}, 32'd0);
        chk("ro_fetch_count", fetch_count, 32'd4);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_npc", npc_out, 32'h0000_0000);
        advance();

        drive(1'b1, 1'b1, 32'h4444_4444, 1'b1, 1'b0, 32'h0);
        exp_q.push_back({32'hFFFF_FFFC, 32'h4444_4444});
        sample();
        advance();

        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        sample();
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        advance();

        // Streaming with gnt and rvalid always ready: one instruction per two cycles
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            sample();
            req_pc = pc_in;
            chk("st_req", {31'd0, imem_req}, 32'd1);
            chk("st_npc", npc_out, req_pc + 32'd4);
            advance();
            rd = $urandom;
            drive(1'b1, 1'b1, rd, 1'b1, 1'b0, 32'h0);
            exp_q.push_back({req_pc, rd});
            sample();
            chk("st_wait_valid", {31'd0, inst_valid}, 32'd0);
            advance();
        end

        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        sample();
        advance();
        sample();
        chk("end_fetch_count", fetch_count, 32'd13);
        chk("end_queue_empty", exp_q.size(), 32'd0);
        chk("end_inst_nop", inst, 32'h0000_0013);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Consumes the current PC, issues one instruction-memory request at a time over a req/gnt + rvalid handshake, and presents the fetched instruction plus its PC to decode over a valid/ready handshake.
- Computes the NPC fed back into the PC register: hold, PC+4, or redirect target. The PC register has no enable, so stalls are expressed by returning NPC = PC.

Parameters:
- XLEN, 32, address/data width
- NOP_INST, 32'h00000013, value driven on inst while inst_valid=0

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- pc_in  in  XLEN  current PC from PC register
- npc_out  out  XLEN  next PC to PC register
- redirect_valid  in  1  branch/jump taken, from execute
- redirect_target  in  XLEN  redirect address
- imem_req  out  1  memory request valid
- imem_addr  out  XLEN  request address
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid; exactly one per granted request, ≥1 cycle after gnt
- imem_rdata  in  XLEN  response instruction
- inst_valid  out  1  instruction available to decode
- inst  out  XLEN  instruction word
- inst_pc  out  XLEN  PC of inst
- inst_ready  in  1  decode accepts inst
- fetch_count  out  32  instructions delivered (inst_valid & inst_ready), wraps

Behaviour:
- States: IDLE, WAIT, OUT. Single outstanding request. Registers: state, req_pc, drop, inst, inst_pc, fetch_count.
- Reset: state=IDLE, drop=0, inst_valid=0, inst=NOP_INST, inst_pc=0, fetch_count=0. While rst=1: imem_req=0, npc_out=pc_in.
- Default for all states: npc_out=pc_in (hold).
- IDLE:
  - imem_req=1, imem_addr=pc_in.
  - On gnt: req_pc<=pc_in, npc_out=pc_in+4, go to WAIT.
  - Without gnt: remain in IDLE.
- WAIT:
  - imem_req=0.
  - On rvalid with drop=0: inst<=rdata, inst_pc<=req_pc, go to OUT.
  - On rvalid with drop=1: discard, drop<=0, go to IDLE.
- OUT:
  - inst_valid=1.
  - imem_req = inst_ready, imem_addr=pc_in.
  - inst_ready with gnt: req_pc<=pc_in, npc_out=pc_in+4, go to WAIT.
  - inst_ready without gnt: go to IDLE.
  - No inst_ready: hold inst/inst_pc stable, no request.
- fetch_count increments on inst_valid & inst_ready, modulo 2^32.
- Redirect (highest priority, any state):
  - npc_out = {redirect_target[XLEN-1:2],2'b00}, i.e. low bits forced to zero.
  - imem_req=0 that cycle; no request is issued.
  - OUT: inst_valid drops next cycle, go to IDLE; decode's handshake that cycle still counts if inst_ready=1.
  - WAIT with rvalid the same cycle: discard response, go to IDLE.
  - WAIT without rvalid: drop<=1, stay in WAIT.
  - IDLE: go to IDLE.
  - Redirect while drop=1: target overrides, drop stays 1.
- pc+4 wraps modulo 2^XLEN: 0xFFFFFFFC → 0x00000000.
- Latency:
  - Minimum 2 cycles from request to inst_valid (gnt cycle, response cycle).
  - Steady-state throughput 1 instruction per 2 cycles with gnt and rvalid tied ready.
- Reset mid-WAIT: the outstanding response is not tracked after reset. The memory side is reset concurrently.

Decomposition:
- Shared package:
  - state enum {IDLE, WAIT, OUT}
  - XLEN
  - NOP_INST
  - INST_ALIGN = 4
- Sub-module: npc_mux (combinational select: hold / +4 / redirect, with alignment). Kept separate so a later branch predictor can replace it.

Test Plan:
- Reset with pc_in=0x00000000, gnt=1, rvalid one cycle after gnt, rdata=0x00500093, inst_ready=1:
  - Expect imem_addr=0x0 in the first cycle after reset release, npc_out=0x4 that cycle.
  - Expect inst_valid=1, inst=0x00500093, inst_pc=0x0 two cycles later.
  - Expect fetch_count=1 after accept.
- Backpressure: inst_ready=0 for 3 cycles in OUT:
  - inst and inst_pc stay stable, imem_req=0, npc_out=pc_in.
  - On ready, the next request is at 0x8, following the fetch at 0x4.
- Gnt delay: gnt low for 4 cycles in IDLE:
  - imem_req stays 1 with imem_addr constant, npc_out=pc_in throughout.
- Redirect in WAIT to 0x00000102:
  - npc_out=0x00000100.
  - The pending rvalid (rdata=0xDEADBEEF) is discarded with no inst_valid.
  - The next request is at 0x100.
- Redirect in OUT concurrent with inst_ready=1:
  - fetch_count increments.
  - inst_valid=0 next cycle.
  - npc_out equals the target.
- Wrap: pc_in=0xFFFFFFFC with gnt -> npc_out=0x00000000.
